mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Parametrised multi-cycle integer multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Services MULT, MULTU, DIV and DIVU with a start/busy/done handshake.
- Produces HI/LO results, following the MIPS convention: product high/low; remainder/quotient.
- Iterative radix-2 datapath, one bit per cycle, so the pipeline stalls on busy instead of carrying a combinational multiplier.

Parameters:
- WIDTH, 32, operand width in bits (even, >=4); hi and lo are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  synchronous active-low reset, sampled on CLK rising edge.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV; captured with start.
- port_a  input  WIDTH  multiplicand / dividend; captured with start.
- port_b  input  WIDTH  multiplier / divisor; captured with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse; hi/lo/div_zero are valid from this cycle.
- hi  output  WIDTH  product[2W-1:W] or remainder.
- lo  output  WIDTH  product[W-1:0] or quotient.
- div_zero  output  1  set with done when a DIV/DIVU had port_b==0; held with results.

Behaviour:
- Reset (nRST=0 at a CLK edge):
  - state=IDLE; busy=0, done=0, hi=0, lo=0, div_zero=0; counter cleared.
  - Applies mid-operation too: the in-flight operation is discarded and no done is issued.
- States are IDLE, CALC, SIGN and DONE.

IDLE:
- If start=1, capture op/a/b.
- Signed ops take the magnitudes of a and b and record neg_res and neg_rem (below).
- Divide with b==0 goes directly to DONE. Otherwise go to CALC with counter=WIDTH.
- busy=0.

CALC:
- One iteration per cycle; counter decrements; on counter reaching 0, go to SIGN.
- MUL: shift-add on a 2W accumulator.
- DIV: restoring shift-subtract; the remainder register is W+1 bits.
- busy=1.

SIGN:
- Apply two's-complement negation to the product when neg_res (signed mul).
- For signed div: negate the quotient when neg_res, and negate the remainder when neg_rem (dividend negative).
- Register hi/lo. Go to DONE.

DONE:
- done=1 for exactly this cycle; busy=0. Go to IDLE.
- A start arriving in DONE is ignored. It must be held until IDLE to be sampled.

Latency and handshake:
- Start sampled at edge 0: busy is 1 in cycles 1..WIDTH+1, and done is 1 in cycle WIDTH+2.
- Divide-by-zero: done in cycle 1, with busy=0 throughout.
- start while busy is ignored: no queueing, and no corruption of the operation in flight.
- hi/lo/div_zero hold their values after done until the next done or reset. They do not change during a new operation until its SIGN/DONE.
- div_zero clears on the next accepted start.

Arithmetic:
- neg_res = a[W-1]^b[W-1] (signed ops only); neg_rem = a[W-1] (DIV only).
- Quotient truncates toward zero; the remainder takes the sign of the dividend.
- Signed MULT result is the exact 2W two's-complement product.
- DIV MIN/-1 gives lo=MIN, hi=0, with no overflow flag.
- Divide by zero gives hi=port_a (unmodified), lo={WIDTH{1}}, div_zero=1.
- op[0]=0 treats operands as unsigned.

Test Plan:
- MULTU, WIDTH=32: a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 34 after start; hi=0xFFFFFFFE, lo=0x00000001; busy high in cycles 1..33.
- MULT: a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU: a=100, b=7 -> lo=14, hi=2, div_zero=0. Then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU: a=0x1234, b=0 -> done in cycle 1, div_zero=1, hi=0x1234, lo=0xFFFFFFFF. The next MULTU 2*3 clears div_zero, giving lo=6.
- Start pulsed again at cycle 5 of a MULTU 5*6 -> ignored; single done at cycle 34 with lo=30. Then nRST=0 at cycle 10 of a new op -> all outputs 0 next cycle, no done.
- WIDTH=8 instance: MULT a=0x80, b=0x80 -> done at cycle 10, hi=0x40, lo=0x00.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative radix-2 multiply/divide unit for the execute stage. Handles
//   MULTU, MULT, DIVU and DIV one bit per cycle and returns MIPS-style HI/LO
//   (product high/low, or remainder/quotient).
//
// Ports
//   CLK      : system clock, rising edge
//   nRST     : synchronous active-low reset
//   start    : operation request, only looked at while idle
//   op       : 00=MULTU 01=MULT 10=DIVU 11=DIV, captured with start
//   port_a   : multiplicand / dividend, captured with start
//   port_b   : multiplier / divisor, captured with start
//   busy     : high while an operation is in flight
//   done     : one-cycle pulse, hi/lo/div_zero valid from this cycle on
//   hi       : product upper half or remainder
//   lo       : product lower half or quotient
//   div_zero : divide with a zero divisor, held alongside hi/lo
module mul_div_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_final;
  logic [WIDTH-1:0]   quo_final;
  logic [WIDTH-1:0]   rem_final;

  // Signed requests work on magnitudes; the most negative value maps onto
  // itself, which read as unsigned is exactly its magnitude.
  assign a_neg = op[0] & port_a[WIDTH-1];
  assign b_neg = op[0] & port_b[WIDTH-1];
  assign a_mag = a_neg ? -port_a : port_a;
  assign b_mag = b_neg ? -port_b : port_b;

  // Shift-add step: the multiplier sits in the low half of acc and is
  // consumed LSB first while partial sums enter from the top.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

  // Restoring divide step: a borrow out of the top bit means the shifted
  // remainder was smaller than the divisor.
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_diff  = div_shift - {2'b00, opnd};
  assign div_ge    = ~div_diff[WIDTH+1];

  // Sign fix-up applied once the magnitudes are complete.
  assign prod_final = neg_res ? -acc : acc;
  assign quo_final  = neg_res ? -quo : quo;
  assign rem_final  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  // Control FSM and datapath share one register block so busy/done and the
  // result registers change on the same edges as the state.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            is_div   <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= op[1] & a_neg;
            div_zero <= 1'b0;
            if (op[1] && (port_b == '0)) begin
              // Zero divisor skips the datapath; hi returns the raw dividend.
              hi       <= port_a;
              lo       <= '1;
              div_zero <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              opnd  <= op[1] ? b_mag : a_mag;
              acc   <= {{WIDTH{1'b0}}, b_mag};
              rem   <= '0;
              quo   <= a_mag;
              cnt   <= CNT_W'(WIDTH);
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (is_div) begin
            rem <= div_ge ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
            quo <= {quo[WIDTH-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (cnt == CNT_W'(1)) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          if (is_div) begin
            hi <= rem_final;
            lo <= quo_final;
          end else begin
            hi <= prod_final[2*WIDTH-1:WIDTH];
            lo <= prod_final[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Scoreboard bench for mul_div_unit. Stimulus pushes the hand-computed
//   result and completion cycle of each request; per-instance monitors pop
//   and compare whenever done is seen. A 32-bit and an 8-bit instance share
//   the clock and reset.
module tb_mul_div_unit;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          done_cyc;
  } exp_t;

  logic        CLK;
  logic        nRST;

  logic        start32;
  logic [1:0]  op32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        busy32;
  logic        done32;
  logic [31:0] hi32;
  logic [31:0] lo32;
  logic        dz32;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;
  logic        dz8;

  int   cyc;
  int   n_checks;
  int   n_pass;
  exp_t q32[$];
  exp_t q8[$];

  mul_div_unit #(.WIDTH(32)) u_dut32 (
    .CLK(CLK), .nRST(nRST), .start(start32), .op(op32),
    .port_a(a32), .port_b(b32), .busy(busy32), .done(done32),
    .hi(hi32), .lo(lo32), .div_zero(dz32)
  );

  mul_div_unit #(.WIDTH(8)) u_dut8 (
    .CLK(CLK), .nRST(nRST), .start(start8), .op(op8),
    .port_a(a8), .port_b(b8), .busy(busy8), .done(done8),
    .hi(hi8), .lo(lo8), .div_zero(dz8)
  );

  // Free-running clock and an edge counter used to time completions.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Issues one request and records what it must produce and when. Returns
  // on the negedge of cycle 1 of the operation.
  task automatic applyStimulus(input bit w8, input string name, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ehi, input logic [31:0] elo,
                               input logic edz);
    exp_t e;
    int   lat;
    @(negedge CLK);
    lat        = edz ? 1 : (w8 ? 10 : 34);
    e.name     = name;
    e.hi       = ehi;
    e.lo       = elo;
    e.dz       = edz;
    e.done_cyc = cyc + lat;
    if (w8) begin
      start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
      q8.push_back(e);
    end else begin
      start32 = 1'b1; op32 = op; a32 = a; b32 = b;
      q32.push_back(e);
    end
    @(negedge CLK);
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  // Waits (bounded) for the monitor to consume every pending result, then
  // one more cycle so the unit is back in IDLE.
  task automatic waitDrain(input bit w8);
    for (int i = 0; i < 60; i++) begin
      if ((w8 ? q8.size() : q32.size()) == 0) break;
      @(negedge CLK);
    end
    if ((w8 ? q8.size() : q32.size()) != 0) begin
      checkOutput(w8 ? "timeout8" : "timeout32", 32'(w8 ? q8.size() : q32.size()), 32'd0);
      if (w8) q8.delete(); else q32.delete();
    end
    @(negedge CLK);
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge CLK) begin : mon32
    exp_t e;
    if (done32) begin
      if (q32.size() == 0) begin
        checkOutput("unexpected_done32", 32'(done32), 32'd0);
      end else begin
        e = q32.pop_front();
        checkOutput({e.name, "_hi"}, hi32, e.hi);
        checkOutput({e.name, "_lo"}, lo32, e.lo);
        checkOutput({e.name, "_dz"}, 32'(dz32), 32'(e.dz));
        checkOutput({e.name, "_cycle"}, 32'(cyc), 32'(e.done_cyc));
        checkOutput({e.name, "_busy"}, 32'(busy32), 32'd0);
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge CLK) begin : mon8
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) begin
        checkOutput("unexpected_done8", 32'(done8), 32'd0);
      end else begin
        e = q8.pop_front();
        checkOutput({e.name, "_hi"}, 32'(hi8), e.hi);
        checkOutput({e.name, "_lo"}, 32'(lo8), e.lo);
        checkOutput({e.name, "_dz"}, 32'(dz8), 32'(e.dz));
        checkOutput({e.name, "_cycle"}, 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    n_checks = 0;
    n_pass   = 0;
    nRST = 1'b0;
    start32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
    start8  = 1'b0; op8  = 2'b00; a8  = '0; b8  = '0;
    repeat (3) @(negedge CLK);

    checkOutput("rst_busy32", 32'(busy32), 32'd0);
    checkOutput("rst_done32", 32'(done32), 32'd0);
    checkOutput("rst_hi32", hi32, 32'd0);
    checkOutput("rst_lo32", lo32, 32'd0);
    checkOutput("rst_dz32", 32'(dz32), 32'd0);
    checkOutput("rst_busy8", 32'(busy8), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    // Full-scale unsigned product with busy window checks.
    applyStimulus(0, "multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    checkOutput("multu_max_busy_c1", 32'(busy32), 32'd1);
    repeat (32) @(negedge CLK);
    checkOutput("multu_max_busy_c33", 32'(busy32), 32'd1);
    waitDrain(0);

    applyStimulus(0, "mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7,
                  32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    waitDrain(0);
    applyStimulus(0, "mult_neg5xneg4", 2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFC,
                  32'h0, 32'd20, 1'b0);
    waitDrain(0);
    applyStimulus(0, "div_neg7by2", 2'b11, 32'hFFFF_FFF9, 32'd2,
                  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    waitDrain(0);
    applyStimulus(0, "div_7byneg2", 2'b11, 32'd7, 32'hFFFF_FFFE,
                  32'd1, 32'hFFFF_FFFD, 1'b0);
    waitDrain(0);
    applyStimulus(0, "divu_100by7", 2'b10, 32'd100, 32'd7,
                  32'd2, 32'd14, 1'b0);
    waitDrain(0);
    applyStimulus(0, "div_min_by_neg1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'h0, 32'h8000_0000, 1'b0);
    waitDrain(0);

    // Divide by zero, then a multiply that must clear div_zero on accept.
    applyStimulus(0, "divu_by0", 2'b10, 32'h0000_1234, 32'd0,
                  32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    waitDrain(0);
    applyStimulus(0, "multu_2x3", 2'b00, 32'd2, 32'd3,
                  32'd0, 32'd6, 1'b0);
    checkOutput("dz_cleared_on_start", 32'(dz32), 32'd0);
    checkOutput("hi_held_during_op", hi32, 32'h0000_1234);
    checkOutput("lo_held_during_op", lo32, 32'hFFFF_FFFF);
    waitDrain(0);
    applyStimulus(0, "div_neg5_by0", 2'b11, 32'hFFFF_FFFB, 32'd0,
                  32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    waitDrain(0);

    // A second start during CALC (a divide-by-zero if it were taken).
    applyStimulus(0, "multu_5x6", 2'b00, 32'd5, 32'd6,
                  32'd0, 32'd30, 1'b0);
    repeat (4) @(negedge CLK);
    start32 = 1'b1; op32 = 2'b10; a32 = 32'd7; b32 = 32'd0;
    checkOutput("busy_at_restart", 32'(busy32), 32'd1);
    @(negedge CLK);
    start32 = 1'b0;
    waitDrain(0);

    // Reset in the middle of an operation: no done may follow.
    applyStimulus(0, "multu_9x9_aborted", 2'b00, 32'd9, 32'd9,
                  32'd0, 32'd81, 1'b0);
    repeat (9) @(negedge CLK);
    checkOutput("lo_held_before_reset", lo32, 32'd30);
    nRST = 1'b0;
    @(negedge CLK);
    q32.delete();
    checkOutput("midrst_busy", 32'(busy32), 32'd0);
    checkOutput("midrst_done", 32'(done32), 32'd0);
    checkOutput("midrst_hi", hi32, 32'd0);
    checkOutput("midrst_lo", lo32, 32'd0);
    checkOutput("midrst_dz", 32'(dz32), 32'd0);
    nRST = 1'b1;
    repeat (40) @(negedge CLK);
    checkOutput("post_rst_idle_busy", 32'(busy32), 32'd0);

    // Narrow instance.
    applyStimulus(1, "mult8_min_sq", 2'b01, 32'h80, 32'h80,
                  32'h40, 32'h00, 1'b0);
    waitDrain(1);
    applyStimulus(1, "div8_neg127by5", 2'b11, 32'h81, 32'h05,
                  32'hFE, 32'hE7, 1'b0);
    waitDrain(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
